// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - memory-mapped GPIO peripheral with input sync, change flags and irq
module gpio_ctrl #(
    parameter int                 WIDTH       = 32,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]   GPO1_RST    = '0,
    parameter logic [WIDTH-1:0]   GPO2_RST    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    output logic [WIDTH-1:0] rd,
    output logic             rd_valid,
    input  logic [WIDTH-1:0] gpi1,
    input  logic [WIDTH-1:0] gpi2,
    output logic [WIDTH-1:0] gpo1,
    output logic [WIDTH-1:0] gpo2,
    output logic             irq
);

    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync1;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0]                  r_prev1;
    logic [WIDTH-1:0]                  r_prev2;
    logic [2:0]                        r_arm_cnt;
    logic [1:0]                        r_chg;
    logic [1:0]                        r_ien;
    logic [WIDTH-1:0]                  r_gpo1;
    logic [WIDTH-1:0]                  r_gpo2;
    logic [WIDTH-1:0]                  r_rd;
    logic                              r_rd_valid;
    logic                              r_irq;

    logic [WIDTH-1:0] w_s1;
    logic [WIDTH-1:0] w_s2;
    logic             w_armed;
    logic [1:0]       w_set;
    logic [1:0]       w_clr;
    logic [1:0]       w_chg_nxt;
    logic [1:0]       w_ien_nxt;
    logic [WIDTH-1:0] w_rd_mux;

    assign w_s1    = r_sync1[SYNC_STAGES-1];
    assign w_s2    = r_sync2[SYNC_STAGES-1];
    assign w_armed = (r_arm_cnt == ARM_LAST);

    // Set beats clear when both hit the same flag in one cycle.
    always_comb begin
        w_set     = '0;
        w_clr     = '0;
        w_ien_nxt = r_ien;
        if (w_armed) begin
            w_set[0] = (w_s1 != r_prev1);
            w_set[1] = (w_s2 != r_prev2);
        end
        if (we && addr == 3'd4) w_clr = wd[1:0];
        if (we && addr == 3'd5) w_ien_nxt = wd[1:0];
        w_chg_nxt = (r_chg & ~w_clr) | w_set;
    end

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            3'd0:    w_rd_mux = w_s1;
            3'd1:    w_rd_mux = w_s2;
            3'd2:    w_rd_mux = r_gpo1;
            3'd3:    w_rd_mux = r_gpo2;
            3'd4:    w_rd_mux = {{(WIDTH-2){1'b0}}, r_chg};
            3'd5:    w_rd_mux = {{(WIDTH-2){1'b0}}, r_ien};
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_prev1    <= '0;
            r_prev2    <= '0;
            r_arm_cnt  <= '0;
            r_chg      <= '0;
            r_ien      <= '0;
            r_gpo1     <= GPO1_RST;
            r_gpo2     <= GPO2_RST;
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_sync1 <= {r_sync1[SYNC_STAGES-2:0], gpi1};
            r_sync2 <= {r_sync2[SYNC_STAGES-2:0], gpi2};
            r_prev1 <= w_s1;
            r_prev2 <= w_s2;
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 3'd1;
            r_chg <= w_chg_nxt;
            r_ien <= w_ien_nxt;
            if (we && addr == 3'd2) r_gpo1 <= wd;
            if (we && addr == 3'd3) r_gpo2 <= wd;
            r_rd_valid <= re;
            if (re) r_rd <= w_rd_mux;
            r_irq <= |(w_chg_nxt & w_ien_nxt);
        end
    end

    assign rd       = r_rd;
    assign rd_valid = r_rd_valid;
    assign gpo1     = r_gpo1;
    assign gpo2     = r_gpo2;
    assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed table-driven bench for gpio_ctrl
module tb_gpio_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic        re;
    logic [31:0] rd;
    logic        rd_valid;
    logic [31:0] gpi1;
    logic [31:0] gpi2;
    logic [31:0] gpo1;
    logic [31:0] gpo2;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2), .GPO1_RST(32'h0), .GPO2_RST(32'h0)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wd(wd), .re(re),
        .rd(rd), .rd_valid(rd_valid), .gpi1(gpi1), .gpi2(gpi2),
        .gpo1(gpo1), .gpo2(gpo2), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        bit          is_rd;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [31:0] exp_gpo1;
        logic [31:0] exp_gpo2;
        string       name;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wd = d;
        step();
        we = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
        re = 1'b1; addr = a;
        step();
        re = 1'b0;
        chk({name, "_valid"}, {31'b0, rd_valid}, 32'd1);
        chk(name, rd, exp);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wd = '0;
        gpi1 = 32'hFFFF_FFFF; gpi2 = 32'h0;

        tbl[0]  = '{1, 0, 3'd2, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'h0,         "wr_gpo1"};
        tbl[1]  = '{1, 0, 3'd3, 32'h0000_00C4, 32'h0,         32'hDEAD_BEEF, 32'h0000_00C4, "wr_gpo2"};
        tbl[2]  = '{0, 1, 3'd2, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_00C4, "rd_gpo1"};
        tbl[3]  = '{0, 1, 3'd3, 32'h0,         32'h0000_00C4, 32'hDEAD_BEEF, 32'h0000_00C4, "rd_gpo2"};
        tbl[4]  = '{1, 0, 3'd5, 32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF, 32'h0000_00C4, "wr_ien_all"};
        tbl[5]  = '{0, 1, 3'd5, 32'h0,         32'h0000_0003, 32'hDEAD_BEEF, 32'h0000_00C4, "rd_ien_masked"};
        tbl[6]  = '{1, 0, 3'd5, 32'h0,         32'h0,         32'hDEAD_BEEF, 32'h0000_00C4, "wr_ien_zero"};
        tbl[7]  = '{1, 0, 3'd0, 32'h1234_5678, 32'h0,         32'hDEAD_BEEF, 32'h0000_00C4, "wr_gpi1_ignored"};
        tbl[8]  = '{0, 1, 3'd0, 32'h0,         32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0000_00C4, "rd_gpi1"};
        tbl[9]  = '{1, 0, 3'd7, 32'hAAAA_5555, 32'h0,         32'hDEAD_BEEF, 32'h0000_00C4, "wr_unmapped"};
        tbl[10] = '{0, 1, 3'd7, 32'h0,         32'h0,         32'hDEAD_BEEF, 32'h0000_00C4, "rd_addr7"};
        tbl[11] = '{0, 1, 3'd6, 32'h0,         32'h0,         32'hDEAD_BEEF, 32'h0000_00C4, "rd_addr6"};

        // reset state with gpi1 held high
        #12;
        chk("rst_gpo1", gpo1, 32'h0);
        chk("rst_gpo2", gpo2, 32'h0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        step();
        rst = 1'b1;
        repeat (10) step();
        chk("arm_irq", {31'b0, irq}, 32'd0);
        rd_chk(3'd4, 32'h0, "arm_chg");
        rd_chk(3'd0, 32'hFFFF_FFFF, "arm_gpi1");
        chk("arm_gpo1", gpo1, 32'h0);
        chk("arm_gpo2", gpo2, 32'h0);

        for (int i = 0; i < 12; i++) begin
            we = tbl[i].is_wr; re = tbl[i].is_rd; addr = tbl[i].a; wd = tbl[i].d;
            step();
            we = 1'b0; re = 1'b0;
            chk({tbl[i].name, "_valid"}, {31'b0, rd_valid}, {31'b0, tbl[i].is_rd});
            if (tbl[i].is_rd) chk(tbl[i].name, rd, tbl[i].exp_rd);
            chk({tbl[i].name, "_gpo1"}, gpo1, tbl[i].exp_gpo1);
            chk({tbl[i].name, "_gpo2"}, gpo2, tbl[i].exp_gpo2);
        end
        step();
        chk("valid_drops", {31'b0, rd_valid}, 32'd0);
        chk("rd_holds", rd, 32'h0);

        // gpi1 change with IEN[0] enabled: flag after SYNC_STAGES+1 edges
        wr(3'd5, 32'h1);
        gpi1 = 32'hFFFF_FFFE;
        repeat (2) step();
        chk("chg1_irq_early", {31'b0, irq}, 32'd0);
        step();
        chk("chg1_irq", {31'b0, irq}, 32'd1);
        rd_chk(3'd4, 32'h1, "chg1_flag");
        wr(3'd4, 32'h1);
        chk("chg1_clr_irq", {31'b0, irq}, 32'd0);
        rd_chk(3'd4, 32'h0, "chg1_cleared");

        // gpi2 change with IEN=0, then enabling IEN[1] raises irq on that edge
        wr(3'd5, 32'h0);
        gpi2 = 32'h1;
        repeat (3) step();
        chk("chg2_irq_masked", {31'b0, irq}, 32'd0);
        rd_chk(3'd4, 32'h2, "chg2_flag");
        wr(3'd5, 32'h2);
        chk("ien2_irq", {31'b0, irq}, 32'd1);
        wr(3'd5, 32'h0);
        chk("ien2_off_irq", {31'b0, irq}, 32'd0);

        // clear both on the edge gpi1's change is detected: set wins on bit 0
        gpi1 = 32'hFFFF_FFFF;
        repeat (2) step();
        wr(3'd4, 32'h3);
        rd_chk(3'd4, 32'h1, "set_wins");
        wr(3'd4, 32'h3);
        rd_chk(3'd4, 32'h0, "all_cleared");

        // same-cycle write and read of GPO1
        wr(3'd2, 32'h5);
        we = 1'b1; re = 1'b1; addr = 3'd2; wd = 32'h9;
        step();
        we = 1'b0;
        chk("rw_same_old", rd, 32'h5);
        chk("rw_same_gpo1", gpo1, 32'h9);
        // re still high: back-to-back reads
        step();
        chk("b2b_0_valid", {31'b0, rd_valid}, 32'd1);
        chk("b2b_0", rd, 32'h9);
        addr = 3'd3;
        step();
        chk("b2b_1_valid", {31'b0, rd_valid}, 32'd1);
        chk("b2b_1", rd, 32'h0000_00C4);

        // reset mid-read
        addr = 3'd2;
        step();
        chk("pre_rst_valid", {31'b0, rd_valid}, 32'd1);
        rst = 1'b0;
        #1;
        re = 1'b0;
        chk("mid_rst_valid", {31'b0, rd_valid}, 32'd0);
        chk("mid_rst_rd", rd, 32'h0);
        chk("mid_rst_gpo1", gpo1, 32'h0);
        step();
        rst = 1'b1;
        repeat (10) step();
        chk("rearm_irq", {31'b0, irq}, 32'd0);
        rd_chk(3'd4, 32'h0, "rearm_chg");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
